// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the memory-port arbiter
// and its outstanding-owner FIFO.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } mem_owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int MEM_ARB_MAX_OUTSTANDING = 4;

  // The requester that is not 'owner'; used for round-robin tie breaks.
  function automatic mem_owner_e other_owner(input mem_owner_e owner);
    return (owner == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: in-order record of which requester owns each outstanding
// memory transaction. Head is read combinationally so responses route in the
// same cycle they arrive. DEPTH must be a power of two so pointers wrap freely.
module arb_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_ARB_MAX_OUTSTANDING
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  mem_owner_e push_owner_i,
  input  logic       pop_i,
  output mem_owner_e head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_owner_e       owner_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_reg == CNT_W'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = owner_mem[rd_ptr_reg];

  // Storage write; entries need no reset because empty_o guards the head.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      owner_mem[wr_ptr_reg] <= push_owner_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data
// requesters. Round-robin with request locking: a request presented but not
// granted stays selected until it is accepted. Responses return in order and
// are routed by the owner FIFO. Optional perf counters behind MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  output logic              inst_grnt_o,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_valid_o,
  input  logic              data_req_i,
  output logic              data_grnt_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_ren_i,
  input  logic              data_wen_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_valid_o,
  output logic              mem_req_o,
  input  logic              mem_grnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_valid_i,
  output logic              proto_err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_inst_cnt_o,
  output logic [31:0]       perf_data_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  arb_state_e state_reg;
  mem_owner_e lock_owner_reg;
  mem_owner_e last_owner_reg;
  logic       proto_err_reg;

  mem_owner_e sel_owner;
  logic       sel_req;
  logic       transfer;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  mem_owner_e fifo_head;
  logic       stray_rsp;
  logic       locked_drop;
  logic       rw_conflict;

  // Owner selection: frozen while locked, otherwise sole requester or round-robin.
  always_comb begin
    sel_owner = OWNER_INST;
    sel_req   = 1'b0;
    if (state_reg == ARB_LOCKED) begin
      sel_owner = lock_owner_reg;
      sel_req   = (lock_owner_reg == OWNER_INST) ? inst_req_i : data_req_i;
    end else if (inst_req_i && data_req_i) begin
      sel_owner = other_owner(last_owner_reg);
      sel_req   = 1'b1;
    end else if (inst_req_i) begin
      sel_owner = OWNER_INST;
      sel_req   = 1'b1;
    end else if (data_req_i) begin
      sel_owner = OWNER_DATA;
      sel_req   = 1'b1;
    end
  end

  // A full FIFO blocks the request; the registered count makes a same-cycle pop irrelevant.
  assign mem_req_o   = sel_req & ~fifo_full;
  assign transfer    = mem_req_o & mem_grnt_i;
  assign inst_grnt_o = transfer & (sel_owner == OWNER_INST);
  assign data_grnt_o = transfer & (sel_owner == OWNER_DATA);

  // Zero-latency request mux; fetches are always reads, ren+wen collapses to a write.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    if (mem_req_o) begin
      if (sel_owner == OWNER_INST) begin
        mem_addr_o = inst_addr_i;
        mem_ren_o  = 1'b1;
      end else begin
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_wen_o   = data_wen_i;
        mem_ren_o   = data_ren_i & ~data_wen_i;
      end
    end
  end

  // Response routing follows the FIFO head; read data fans out to both requesters.
  assign fifo_pop     = mem_valid_i & ~fifo_empty;
  assign inst_valid_o = fifo_pop & (fifo_head == OWNER_INST);
  assign data_valid_o = fifo_pop & (fifo_head == OWNER_DATA);
  assign inst_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;

  assign stray_rsp   = mem_valid_i & fifo_empty;
  assign locked_drop = (state_reg == ARB_LOCKED) & ~sel_req;
  assign rw_conflict = data_req_i & data_ren_i & data_wen_i;
  assign proto_err_o = proto_err_reg;

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (transfer),
    .push_owner_i (sel_owner),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Arbiter FSM: lock on an ungranted request, release on grant or on a dropped request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ARB_IDLE;
      lock_owner_reg <= OWNER_INST;
      last_owner_reg <= OWNER_DATA;
      proto_err_reg  <= 1'b0;
    end else begin
      if (transfer) last_owner_reg <= sel_owner;
      if (stray_rsp || locked_drop || rw_conflict) proto_err_reg <= 1'b1;
      case (state_reg)
        ARB_IDLE: begin
          if (mem_req_o && !mem_grnt_i) begin
            state_reg      <= ARB_LOCKED;
            lock_owner_reg <= sel_owner;
          end
        end
        ARB_LOCKED: begin
          if (!sel_req || transfer) state_reg <= ARB_IDLE;
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_inst_cnt_reg;
  logic [31:0] perf_data_cnt_reg;
  logic [31:0] perf_stall_cnt_reg;

  // Free-running wrap-around counters of accepted transfers and stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_inst_cnt_reg  <= '0;
      perf_data_cnt_reg  <= '0;
      perf_stall_cnt_reg <= '0;
    end else begin
      if (inst_grnt_o) perf_inst_cnt_reg <= perf_inst_cnt_reg + 1'b1;
      if (data_grnt_o) perf_data_cnt_reg <= perf_data_cnt_reg + 1'b1;
      if ((mem_req_o && !mem_grnt_i) || ((inst_req_i || data_req_i) && fifo_full))
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 1'b1;
    end
  end

  assign perf_inst_cnt_o  = perf_inst_cnt_reg;
  assign perf_data_cnt_o  = perf_data_cnt_reg;
  assign perf_stall_cnt_o = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model (pending requests, committed winner, owner queue).
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXO   = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              inst_req_i = 1'b0;
  logic              inst_grnt_o;
  logic [ADDR_W-1:0] inst_addr_i = '0;
  logic [DATA_W-1:0] inst_rdata_o;
  logic              inst_valid_o;
  logic              data_req_i = 1'b0;
  logic              data_grnt_o;
  logic [ADDR_W-1:0] data_addr_i = '0;
  logic [DATA_W-1:0] data_wdata_i = '0;
  logic              data_ren_i = 1'b0;
  logic              data_wen_i = 1'b0;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_valid_o;
  logic              mem_req_o;
  logic              mem_grnt_i = 1'b0;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ren_o;
  logic              mem_wen_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_valid_i = 1'b0;
  logic              proto_err_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_inst_cnt_o;
  logic [31:0]       perf_data_cnt_o;
  logic [31:0]       perf_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_req_i   (inst_req_i),
    .inst_grnt_o  (inst_grnt_o),
    .inst_addr_i  (inst_addr_i),
    .inst_rdata_o (inst_rdata_o),
    .inst_valid_o (inst_valid_o),
    .data_req_i   (data_req_i),
    .data_grnt_o  (data_grnt_o),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_ren_i   (data_ren_i),
    .data_wen_i   (data_wen_i),
    .data_rdata_o (data_rdata_o),
    .data_valid_o (data_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_grnt_i   (mem_grnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ren_o    (mem_ren_o),
    .mem_wen_o    (mem_wen_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_valid_i  (mem_valid_i),
    .proto_err_o  (proto_err_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_inst_cnt_o  (perf_inst_cnt_o),
    .perf_data_cnt_o  (perf_data_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req_i = 1'b0; inst_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
    data_ren_i = 1'b0; data_wen_i = 1'b0;
    mem_grnt_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Randomized-phase model state
  int  exp_q[$];
  int  commit_w;
  int  last_w;
  int  win;
  int  head;
  bit  ipend, dpend, full, e_req, e_x;
  int  ni, nd;

  initial begin
    // ---- reset state
    do_reset();
    #1;
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_grants", {inst_grnt_o, data_grnt_o}, 0);
    check_eq("rst_valids", {inst_valid_o, data_valid_o}, 0);
    check_eq("rst_proto_err", proto_err_o, 0);

    // ---- fetch only, response two cycles after grant
    @(negedge clk_i);
    inst_req_i = 1'b1; inst_addr_i = 32'h100; mem_grnt_i = 1'b1;
    #1;
    check_eq("t1_inst_grnt", inst_grnt_o, 1);
    check_eq("t1_data_grnt", data_grnt_o, 0);
    check_eq("t1_addr", mem_addr_o, 32'h100);
    check_eq("t1_wen_ren", {mem_wen_o, mem_ren_o}, 2'b01);
    @(negedge clk_i);
    inst_req_i = 1'b0; mem_grnt_i = 1'b0;
    #1 check_eq("t1_no_req", mem_req_o, 0);
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_rdata_i = 32'hFCE08793;
    #1;
    check_eq("t1_inst_valid", inst_valid_o, 1);
    check_eq("t1_inst_rdata", inst_rdata_o, 32'hFCE08793);
    check_eq("t1_data_valid", data_valid_o, 0);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1 check_eq("t1_proto_err", proto_err_o, 0);

    // ---- both requesting: strict alternation starting with inst
    do_reset();
    ni = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      inst_req_i = 1'b1; inst_addr_i = 32'h1000 + i;
      data_req_i = 1'b1; data_addr_i = 32'h2000 + i; data_ren_i = 1'b1;
      mem_grnt_i = 1'b1; mem_valid_i = (i > 0); mem_rdata_i = i;
      #1;
      check_eq("t2_inst_grnt", inst_grnt_o, (i % 2 == 0));
      check_eq("t2_data_grnt", data_grnt_o, (i % 2 == 1));
      if (i > 0) begin
        check_eq("t2_rsp_inst", inst_valid_o, ((i - 1) % 2 == 0));
        check_eq("t2_rsp_data", data_valid_o, ((i - 1) % 2 == 1));
      end
      ni += int'(inst_grnt_o);
      nd += int'(data_grnt_o);
    end
    check_eq("t2_balance", ((ni > nd) ? ni - nd : nd - ni) <= 1, 1);
    @(negedge clk_i);
    idle_inputs(); mem_valid_i = 1'b1;
    #1 check_eq("t2_drain_data", data_valid_o, 1);

    // ---- lock: data stalled three cycles, inst arrives meanwhile
    do_reset();
    @(negedge clk_i);
    data_req_i = 1'b1; data_addr_i = 32'h200; data_wdata_i = 32'hDEADBEEF; data_wen_i = 1'b1;
    #1 check_eq("t3_c1_addr", mem_addr_o, 32'h200);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk_i);
      inst_req_i = 1'b1; inst_addr_i = 32'h300;
      #1;
      check_eq("t3_locked_addr", mem_addr_o, 32'h200);
      check_eq("t3_locked_inst_grnt", inst_grnt_o, 0);
    end
    @(negedge clk_i);
    mem_grnt_i = 1'b1;
    #1;
    check_eq("t3_data_grnt", data_grnt_o, 1);
    check_eq("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
    check_eq("t3_wen_ren", {mem_wen_o, mem_ren_o}, 2'b10);
    @(negedge clk_i);
    data_req_i = 1'b0; data_wen_i = 1'b0;
    #1;
    check_eq("t3_inst_grnt", inst_grnt_o, 1);
    check_eq("t3_inst_addr", mem_addr_o, 32'h300);
    @(negedge clk_i);
    idle_inputs(); mem_valid_i = 1'b1;
    #1 check_eq("t3_rsp1_data", data_valid_o, 1);
    @(negedge clk_i);
    #1 check_eq("t3_rsp2_inst", inst_valid_o, 1);

    // ---- FIFO full blocks the 5th request, even with a same-cycle pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      inst_req_i = 1'b1; data_req_i = 1'b1; data_ren_i = 1'b1; mem_grnt_i = 1'b1;
      #1 check_eq("t4_fill_grnt", {inst_grnt_o, data_grnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge clk_i);
    #1;
    check_eq("t4_full_req", mem_req_o, 0);
    check_eq("t4_full_grnt", {inst_grnt_o, data_grnt_o}, 0);
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_rdata_i = 32'hA0;
    #1;
    check_eq("t4_pop_cycle_req", mem_req_o, 0);
    check_eq("t4_pop_inst_valid", inst_valid_o, 1);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1;
    check_eq("t4_after_pop_req", mem_req_o, 1);
    check_eq("t4_after_pop_grnt", inst_grnt_o, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      idle_inputs(); mem_valid_i = 1'b1;
      #1;
      check_eq("t4_order_data", data_valid_o, (k % 2 == 0));
      check_eq("t4_order_inst", inst_valid_o, (k % 2 == 1));
    end

    // ---- stray response, sticky error, reset clears FIFO and error
    do_reset();
    @(negedge clk_i);
    data_req_i = 1'b1; data_ren_i = 1'b1; mem_grnt_i = 1'b1;
    #1 check_eq("t5_data_grnt", data_grnt_o, 1);
    @(negedge clk_i);
    idle_inputs(); rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; mem_valid_i = 1'b1;
    #1;
    check_eq("t5_stray_valids", {inst_valid_o, data_valid_o}, 0);
    check_eq("t5_err_not_yet", proto_err_o, 0);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1 check_eq("t5_err_set", proto_err_o, 1);
    @(negedge clk_i);
    #1 check_eq("t5_err_held", proto_err_o, 1);
    do_reset();
    #1 check_eq("t5_err_cleared", proto_err_o, 0);

`ifdef MEM_ARB_PERF_EN
    // ---- perf counters: 3 inst, 2 data, 4 stalls
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      idle_inputs();
      case (c)
        0, 1:    inst_req_i = 1'b1;
        2, 3, 4: begin inst_req_i = 1'b1; mem_grnt_i = 1'b1; end
        5, 6:    begin data_req_i = 1'b1; data_ren_i = 1'b1; end
        7:       begin data_req_i = 1'b1; data_ren_i = 1'b1; mem_grnt_i = 1'b1; end
        8:       mem_valid_i = 1'b1;
        default: begin data_req_i = 1'b1; data_ren_i = 1'b1; mem_grnt_i = 1'b1; end
      endcase
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    check_eq("t6_perf_inst", perf_inst_cnt_o, 3);
    check_eq("t6_perf_data", perf_data_cnt_o, 2);
    check_eq("t6_perf_stall", perf_stall_cnt_o, 4);
`endif

    // ---- randomized run against the transaction model
    do_reset();
    exp_q.delete();
    commit_w = -1; last_w = 1; ipend = 0; dpend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk_i);
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; inst_addr_i = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; data_addr_i = $urandom; data_wdata_i = $urandom;
        data_wen_i = 1'($urandom_range(0, 1)); data_ren_i = ~data_wen_i;
      end
      inst_req_i  = ipend;
      data_req_i  = dpend;
      mem_grnt_i  = ($urandom_range(0, 3) != 0);
      mem_valid_i = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom;
      #1;
      full = (exp_q.size() == MAXO);
      win = -1;
      if (commit_w >= 0)       win = commit_w;
      else if (ipend && dpend) win = (last_w == 1) ? 0 : 1;
      else if (ipend)          win = 0;
      else if (dpend)          win = 1;
      e_req = (win >= 0) && !full;
      e_x   = e_req && mem_grnt_i;
      check_eq("r_mem_req", mem_req_o, e_req);
      check_eq("r_inst_grnt", inst_grnt_o, e_x && win == 0);
      check_eq("r_data_grnt", data_grnt_o, e_x && win == 1);
      if (e_req) begin
        check_eq("r_addr", mem_addr_o, (win == 0) ? inst_addr_i : data_addr_i);
        check_eq("r_wen_ren", {mem_wen_o, mem_ren_o},
                 (win == 0) ? 2'b01 : {data_wen_i, data_ren_i});
        if (win == 1 && data_wen_i) check_eq("r_wdata", mem_wdata_o, data_wdata_i);
      end
      if (mem_valid_i) begin
        head = exp_q.pop_front();
        check_eq("r_rsp_inst", inst_valid_o, head == 0);
        check_eq("r_rsp_data", data_valid_o, head == 1);
        check_eq("r_rdata", (head == 0) ? inst_rdata_o : data_rdata_o, mem_rdata_i);
      end else begin
        check_eq("r_no_rsp", {inst_valid_o, data_valid_o}, 0);
      end
      check_eq("r_proto_err", proto_err_o, 0);
      if (e_x) begin
        exp_q.push_back(win);
        last_w = win;
        commit_w = -1;
        if (win == 0) ipend = 0; else dpend = 0;
        $display("xfer %s addr=0x%08h outstanding=%0d", (win == 0) ? "inst" : "data",
                 mem_addr_o, exp_q.size());
      end else if (e_req) begin
        commit_w = win;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its data-memory requester.
- Arbitration is round-robin with request locking.
- Tracks outstanding transactions in an in-order owner FIFO, so each memory response returns to the requester that issued it.
- Sits between the core's inst_*/data_mem_* ports and the single-port memory model or system bus.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, read/write data width.
- MAX_OUTSTANDING, 4, owner FIFO depth; power of two, ≥2.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous, active-high reset.
- inst_req_i  input  1  instruction fetch request.
- inst_grnt_o  output  1  fetch accepted this cycle.
- inst_addr_i  input  ADDR_W  fetch address.
- inst_rdata_o  output  DATA_W  fetch data.
- inst_valid_o  output  1  fetch response valid.
- data_req_i  input  1  data request.
- data_grnt_o  output  1  data request accepted this cycle.
- data_addr_i  input  ADDR_W  data address.
- data_wdata_i  input  DATA_W  store data.
- data_ren_i  input  1  load.
- data_wen_i  input  1  store.
- data_rdata_o  output  DATA_W  load data.
- data_valid_o  output  1  data response valid (load data or store ack).
- mem_req_o  output  1  memory request.
- mem_grnt_i  input  1  memory accepted the request.
- mem_addr_o  output  ADDR_W  memory address.
- mem_wdata_o  output  DATA_W  memory write data.
- mem_ren_o  output  1  memory read.
- mem_wen_o  output  1  memory write.
- mem_rdata_i  input  DATA_W  memory read data.
- mem_valid_i  input  1  memory response, exactly one per accepted request, in order.
- proto_err_o  output  1  sticky protocol error.

Behaviour:
- Transfer: a request transfers on req & grnt. Requesters hold req/addr/wdata/ren/wen stable until granted.
- Reset: all outputs 0, FIFO empty, state ARB_IDLE, last_owner=OWNER_DATA (so inst wins the first tie).
- FSM ARB_IDLE:
  - Selects the sole requester, or on a tie the requester ≠ last_owner.
  - Drives mem_req_o=1 and muxes addr/wdata/ren/wen combinationally (0-cycle request path).
  - Inst path drives ren=1, wen=0.
  - If mem_grnt_i=0, registers the owner and moves to ARB_LOCKED.
- FSM ARB_LOCKED:
  - Selection frozen to the locked owner regardless of the other requester.
  - On mem_grnt_i returns to ARB_IDLE.
  - If the locked requester drops req, sets proto_err_o and returns to ARB_IDLE.
- Grant rule: {inst,data}_grnt_o = mem_grnt_i & mem_req_o & (owner matches).
- On a transfer: push owner into the FIFO and set last_owner=owner.
- FIFO full: mem_req_o forced 0, no grant. This holds even if a pop occurs the same cycle (full check uses the registered count). Lock state is kept.
- Response routing: combinational, 0-cycle. On mem_valid_i, the FIFO head selects inst_valid_o or data_valid_o. mem_rdata_i is fanned to both rdata outputs. The head is popped.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo MAX_OUTSTANDING.
- mem_valid_i with FIFO empty: response dropped, proto_err_o set. proto_err_o stays set until rst_i.
- Reset mid-operation: lock, FIFO and pointers cleared. The memory shares rst_i, so no stale responses are expected.
- Requester holding both ren and wen: treated as a write, proto_err_o set.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three outputs: perf_inst_cnt_o[31:0] and perf_data_cnt_o[31:0] (granted transfers per requester), and perf_stall_cnt_o[31:0] (cycles with mem_req_o=1 & !mem_grnt_i, plus cycles with any req blocked by FIFO full).
- Counters reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic do not exist; behaviour is otherwise identical.

Decomposition:
- core_pkg additions: mem_owner_e {OWNER_INST, OWNER_DATA}; arb_state_e {ARB_IDLE, ARB_LOCKED}; MEM_ARB_MAX_OUTSTANDING default constant.
- Sub-module arb_owner_fifo:
  - Parameterised depth.
  - Push/pop, head, count, full/empty.
  - Synchronous active-high reset.

Test Plan:
1. Only inst_req_i=1 at addr 0x100, mem_grnt_i=1 every cycle, mem_valid_i 2 cycles after grant with rdata 0xFCE08793 -> inst_grnt_o same cycle; inst_valid_o=1 with inst_rdata_o=0xFCE08793; data_valid_o stays 0.
2. Both requesting continuously, mem_grnt_i=1 -> grants alternate inst, data, inst, data starting with inst after reset; per-port counts differ by ≤1 over 20 cycles.
3. data_req_i at 0x200 with mem_grnt_i=0 for 3 cycles, inst_req_i rising in cycle 2 -> mem_addr_o stays 0x200 (ARB_LOCKED); data granted in cycle 4; inst granted next cycle.
4. 4 grants with no mem_valid_i -> 5th request sees mem_req_o=0 and no grant. One mem_valid_i -> request issued the following cycle. Responses return to owners in issue order.
5. mem_valid_i with FIFO empty -> proto_err_o=1 and held; rst_i pulse -> proto_err_o=0 and FIFO empty.
6. With MEM_ARB_PERF_EN: 3 inst transfers, 2 data transfers, 4 stalled cycles -> perf_inst_cnt_o=3, perf_data_cnt_o=2, perf_stall_cnt_o=4.
